// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// and helpers that turn funct3/offset into an access size and byte-lane mask.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] access_size(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  // Byte-lane enables for an access of this size starting at this offset.
  function automatic logic [7:0] byte_enables(input logic [2:0] funct3,
                                              input logic [2:0] offset);
    logic [15:0] mask;
    mask = ((16'd1 << access_size(funct3)) - 16'd1) << offset;
    return mask[7:0];
  endfunction

endpackage

// File: rtl/dmem_bytelane_array.sv
// Doubleword storage built from eight independent byte lanes; each lane has
// its own write enable, and all lanes share one registered read port.
module dmem_bytelane_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [7:0]            be,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  for (genvar l = 0; l < 8; l++) begin : g_lane
    logic [7:0] lane_q [DEPTH];
    logic [7:0] rd_q;

    // Per-lane write of the enabled byte and registered read of the same row.
    always_ff @(posedge clk) begin
      if (we && be[l]) lane_q[addr] <= wdata[8*l +: 8];
      if (re)          rd_q         <= lane_q[addr];
    end

    assign rdata[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the MEM stage: one request at a time over a
// valid/ready handshake, byte-lane store merge, right-aligned load data,
// fixed access latency, and error flagging for bad accesses.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            wr_q;
  logic [63:0]     addr_q;
  logic [2:0]      f3_q;
  logic [63:0]     wdata_q;

  logic            ok_q;
  logic            err_q;
  logic [2:0]      sh_q;

  logic            accept;
  logic            commit;
  logic            cur_wr;
  logic [63:0]     cur_addr;
  logic [2:0]      cur_f3;
  logic [63:0]     cur_wdata;
  logic [2:0]      cur_off;
  logic            cur_err;
  logic            misaligned;
  logic            out_of_range;
  logic            illegal_f3;
  logic [63:0]     arr_rdata;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign accept     = req_valid && req_ready;

  // With LATENCY == 1 the commit edge is the accept edge, so the live request
  // is used directly; otherwise the latched copy drives the memory.
  assign cur_wr    = (state_q == IDLE) ? req_write  : wr_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr   : addr_q;
  assign cur_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
  assign cur_off   = cur_addr[2:0];

  assign misaligned   = (cur_off & 3'(access_size(cur_f3) - 4'd1)) != 3'd0;
  assign out_of_range = |cur_addr[63:ADDR_WIDTH+3];
  assign illegal_f3   = cur_wr ? cur_f3[2] : (cur_f3 == 3'b111);
  assign cur_err      = misaligned || out_of_range || illegal_f3;

  // Reset on the commit edge cancels the write as well as the response.
  assign commit = !rst && ((LATENCY == 1) ? accept
                                          : (state_q == WAIT && cnt_q == '0));

  dmem_bytelane_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (commit && cur_wr && !cur_err),
    .be    (byte_enables(cur_f3, cur_off)),
    .re    (commit && !cur_wr && !cur_err),
    .addr  (cur_addr[ADDR_WIDTH+2:3]),
    .wdata (cur_wdata << {cur_off, 3'b000}),
    .rdata (arr_rdata)
  );

  assign resp_rdata = ok_q ? (arr_rdata >> {sh_q, 3'b000}) : 64'd0;
  assign resp_error = err_q;

  // FSM state, latency counter and response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        ok_q  <= !cur_wr && !cur_err;
        err_q <= cur_err;
      end
    end
  end

  // Request capture and load shift amount; data path carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      f3_q    <= req_funct3;
      wdata_q <= req_wdata;
    end
    if (commit) sh_q <= cur_off;
  end

  // Next-state logic: IDLE -> WAIT (count down) -> RESP -> IDLE on handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with hand-computed expected values.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [2:0]  req_funct3;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_error;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [63:0] rd;
  logic        er;
  int          lat;

  dmem_responder #(
    .ADDR_WIDTH (10),
    .LATENCY    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // One full transaction; returns data, error and cycles from accept to resp_valid.
  task automatic xact(input logic wr, input logic [63:0] a, input logic [2:0] f3,
                      input logic [63:0] wd, output logic [63:0] rdata,
                      output logic err, output int cycles);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 64'hDEAD_0000_0000_0000;
    req_wdata = 64'h5555_5555_5555_5555;
    cycles = 0;
    while (!resp_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    rdata = resp_rdata;
    err   = resp_error;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_funct3 = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_error", 64'(resp_error), 64'd0);

    // 1: sd then ld
    xact(1'b1, 64'h40, 3'b011, 64'h1122334455667788, rd, er, lat);
    check("t1_sd_lat", 64'(lat), 64'd2);
    check("t1_sd_rdata", rd, 64'd0);
    check("t1_sd_err", 64'(er), 64'd0);
    xact(1'b0, 64'h40, 3'b011, 64'd0, rd, er, lat);
    check("t1_ld_lat", 64'(lat), 64'd2);
    check("t1_ld_rdata", rd, 64'h1122334455667788);
    check("t1_ld_err", 64'(er), 64'd0);

    // 2: sb merge, ld, lb, lw at upper word
    xact(1'b1, 64'h43, 3'b000, 64'hFFFF_FFFF_FFFF_FFAB, rd, er, lat);
    check("t2_sb_err", 64'(er), 64'd0);
    xact(1'b0, 64'h40, 3'b011, 64'd0, rd, er, lat);
    check("t2_ld_rdata", rd, 64'h11223344AB667788);
    xact(1'b0, 64'h43, 3'b000, 64'd0, rd, er, lat);
    check("t2_lb_byte", 64'(rd[7:0]), 64'hAB);
    check("t2_lb_full", rd, 64'h0000_0011_2233_44AB);
    xact(1'b0, 64'h44, 3'b010, 64'd0, rd, er, lat);
    check("t2_lw_hi", rd, 64'h0000_0000_1122_3344);

    // 3: misaligned sw, then memory unchanged; misaligned lh
    xact(1'b1, 64'h42, 3'b010, 64'hDEADBEEF, rd, er, lat);
    check("t3_sw_err", 64'(er), 64'd1);
    check("t3_sw_rdata", rd, 64'd0);
    check("t3_sw_lat", 64'(lat), 64'd2);
    xact(1'b0, 64'h40, 3'b011, 64'd0, rd, er, lat);
    check("t3_ld_rdata", rd, 64'h11223344AB667788);
    xact(1'b0, 64'h41, 3'b001, 64'd0, rd, er, lat);
    check("t3_lh_err", 64'(er), 64'd1);

    // 4: backpressure with a second request waiting
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h40; req_funct3 = 3'b011;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("t4_not_yet", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 64'h43; req_funct3 = 3'b100;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 64'(resp_valid), 64'd1);
      check("t4_hold_rdata", resp_rdata, 64'h11223344AB667788);
      check("t4_hold_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("t4_hs_valid", 64'(resp_valid), 64'd0);
    check("t4_hs_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("t4_acc2_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("t4_acc2_wait", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    check("t4_acc2_valid", 64'(resp_valid), 64'd1);
    check("t4_acc2_rdata", resp_rdata, 64'h0000_0011_2233_44AB);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // 5: out of range, top in-range row, illegal store funct3
    xact(1'b0, 64'h2000, 3'b011, 64'd0, rd, er, lat);
    check("t5_oor_err", 64'(er), 64'd1);
    check("t5_oor_rdata", rd, 64'd0);
    xact(1'b1, 64'h1FF8, 3'b011, 64'h0000_0000_CAFE_F00D, rd, er, lat);
    check("t5_top_sd_err", 64'(er), 64'd0);
    xact(1'b0, 64'h1FF8, 3'b011, 64'd0, rd, er, lat);
    check("t5_top_ld", rd, 64'h0000_0000_CAFE_F00D);
    xact(1'b1, 64'h40, 3'b100, 64'h0, rd, er, lat);
    check("t5_badf3_err", 64'(er), 64'd1);
    xact(1'b0, 64'h40, 3'b111, 64'd0, rd, er, lat);
    check("t5_ldf3_err", 64'(er), 64'd1);
    xact(1'b0, 64'h40, 3'b011, 64'd0, rd, er, lat);
    check("t5_nowrite", rd, 64'h11223344AB667788);

    // 6: reset on the commit edge of a store drops it
    xact(1'b1, 64'h80, 3'b011, 64'h0123456789ABCDEF, rd, er, lat);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h80;
    req_funct3 = 3'b011; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_valid", 64'(resp_valid), 64'd0);
    check("t6_ready", 64'(req_ready), 64'd1);
    check("t6_error", 64'(resp_error), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_still_idle", 64'(resp_valid), 64'd0);
    xact(1'b0, 64'h80, 3'b011, 64'd0, rd, er, lat);
    check("t6_ld_prior", rd, 64'h0123456789ABCDEF);
    check("t6_ld_err", 64'(er), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
